lcd_nibble_writer: RTL

- Downstream transfer engine for the HD44780-style character LCD in 4-bit mode on the 100 MHz board clock.
- Accepts one byte (or one lone nibble) plus RS over a valid/ready handshake.
- Drives DB[7:4], RS, RW and E with the controller's setup, pulse and hold timing, then waits out the instruction execution time before accepting the next transfer.
- The init sequencer and the later character-write logic both feed their writes through this block.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_nibble_writer_if.sv | 11 +
 rtl/lcd_delay_counter.sv | 27 ++
 rtl/lcd_nibble_writer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared timing defaults, FSM encoding and opcodes for the HD44780 4-bit write path.
// Used by the nibble writer, its delay counter and the init sequencer.
package lcd_pkg;

  localparam int DEF_T_SETUP     = 4;
  localparam int DEF_T_PULSE     = 25;
  localparam int DEF_T_HOLD      = 2;
  localparam int DEF_T_GAP       = 100;
  localparam int DEF_T_EXEC      = 4000;
  localparam int DEF_T_EXEC_LONG = 152000;
  localparam int DEF_CNT_W       = 18;

  localparam logic [7:0] LCD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_HOME      = 8'h02;
  localparam logic [7:0] LCD_ENTRY     = 8'h06;
  localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_FUNC_4BIT = 8'h28;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SETUP_H = 4'd1,
    ST_PULSE_H = 4'd2,
    ST_HOLD_H  = 4'd3,
    ST_GAP     = 4'd4,
    ST_SETUP_L = 4'd5,
    ST_PULSE_L = 4'd6,
    ST_HOLD_L  = 4'd7,
    ST_EXEC    = 4'd8
  } lcd_state_e;

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) need the long wait.
  function automatic logic is_long_wait(input logic [7:0] data, input logic rs,
                                        input logic nibble_only);
    return !rs && (data[7:2] == 6'd0) && !nibble_only;
  endfunction

endpackage

// File: rtl/lcd_nibble_writer_if.sv
// Request handshake into the LCD nibble writer: one byte or lone nibble plus RS.
interface lcd_nibble_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_rs;
  logic       in_nibble_only;

  modport master (output in_valid, in_data, in_rs, in_nibble_only, input in_ready);
  modport slave  (input in_valid, in_data, in_rs, in_nibble_only, output in_ready);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter with zero flag; holds at zero. Load takes effect on the next edge.
// No handshake: the owner loads N-1 on entering a timed state and leaves when o_zero is seen.
module lcd_delay_counter #(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_value,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_value;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit write engine: setup/pulse/hold per nibble, then a fixed execution wait; done pulses at the end.
// in_ready is high only in IDLE, so a requester holds in_valid until the previous transfer's done cycle.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int T_SETUP     = DEF_T_SETUP,
  parameter int T_PULSE     = DEF_T_PULSE,
  parameter int T_HOLD      = DEF_T_HOLD,
  parameter int T_GAP       = DEF_T_GAP,
  parameter int T_EXEC      = DEF_T_EXEC,
  parameter int T_EXEC_LONG = DEF_T_EXEC_LONG,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               nrst,
  lcd_nibble_writer_if.slave bus,
  output logic               done,
  output logic [3:0]         DB,
  output logic               RS,
  output logic               RW,
  output logic               E
);

  localparam logic [CNT_W-1:0] L_SETUP     = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] L_PULSE     = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] L_HOLD      = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] L_GAP       = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] L_EXEC      = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] L_EXEC_LONG = CNT_W'(T_EXEC_LONG - 1);

  lcd_state_e       r_state;
  lcd_state_e       w_state_nxt;
  logic             w_accept;
  logic             w_load;
  logic             w_zero;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_exec_val;

  logic [3:0] r_lo;
  logic       r_nib;
  logic       r_long;
  logic [3:0] r_db;
  logic       r_rs;
  logic       r_rw;
  logic       r_e;
  logic       r_done;

  assign bus.in_ready = (r_state == ST_IDLE);
  assign w_accept     = bus.in_valid && (r_state == ST_IDLE);
  assign w_exec_val   = r_long ? L_EXEC_LONG : L_EXEC;

  lcd_delay_counter #(.CNT_W(CNT_W)) u_dly (
    .clk     (clk),
    .nrst    (nrst),
    .i_load  (w_load),
    .i_value (w_load_val),
    .o_zero  (w_zero)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Every transition into a timed state loads that state's length minus one.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      ST_IDLE:    if (w_accept) begin w_state_nxt = ST_SETUP_H; w_load = 1'b1; w_load_val = L_SETUP; end
      ST_SETUP_H: if (w_zero)   begin w_state_nxt = ST_PULSE_H; w_load = 1'b1; w_load_val = L_PULSE; end
      ST_PULSE_H: if (w_zero)   begin w_state_nxt = ST_HOLD_H;  w_load = 1'b1; w_load_val = L_HOLD;  end
      ST_HOLD_H: begin
        if (w_zero) begin
          w_load = 1'b1;
          if (r_nib) begin
            w_state_nxt = ST_EXEC;
            w_load_val  = w_exec_val;
          end else begin
            w_state_nxt = ST_GAP;
            w_load_val  = L_GAP;
          end
        end
      end
      ST_GAP:     if (w_zero)   begin w_state_nxt = ST_SETUP_L; w_load = 1'b1; w_load_val = L_SETUP;    end
      ST_SETUP_L: if (w_zero)   begin w_state_nxt = ST_PULSE_L; w_load = 1'b1; w_load_val = L_PULSE;    end
      ST_PULSE_L: if (w_zero)   begin w_state_nxt = ST_HOLD_L;  w_load = 1'b1; w_load_val = L_HOLD;     end
      ST_HOLD_L:  if (w_zero)   begin w_state_nxt = ST_EXEC;    w_load = 1'b1; w_load_val = w_exec_val; end
      ST_EXEC:    if (w_zero)   begin w_state_nxt = ST_IDLE; end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Pins are decoded from the next state so they switch on the same edge the state does.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_lo   <= '0;
      r_nib  <= 1'b0;
      r_long <= 1'b0;
      r_db   <= '0;
      r_rs   <= 1'b0;
      r_rw   <= 1'b0;
      r_e    <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_rw   <= 1'b0;
      r_e    <= (w_state_nxt == ST_PULSE_H) || (w_state_nxt == ST_PULSE_L);
      r_done <= (r_state == ST_EXEC) && (w_state_nxt == ST_IDLE);
      if (w_accept) begin
        r_lo   <= bus.in_data[3:0];
        r_nib  <= bus.in_nibble_only;
        r_long <= is_long_wait(bus.in_data, bus.in_rs, bus.in_nibble_only);
        r_db   <= bus.in_data[7:4];
        r_rs   <= bus.in_rs;
      end else if ((r_state == ST_GAP) && (w_state_nxt == ST_SETUP_L)) begin
        r_db <= r_lo;
      end
    end
  end

  assign DB   = r_db;
  assign RS   = r_rs;
  assign RW   = r_rw;
  assign E    = r_e;
  assign done = r_done;

endmodule
